// File: rtl/frontend_core_arbiter_pkg.sv
// Shared command definitions for the DRAM frontend: command struct, op encoding
// and the core arbiter FSM states.
package frontend_command_definition_pkg;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_type_t;

  typedef struct packed {
    op_type_t    op_type;
    logic [31:0] addr;
    logic [2:0]  core_id;
    logic [7:0]  req_id;
  } frontend_command_t;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2
  } arb_state_t;

endpackage

// File: rtl/frontend_core_arbiter_if.sv
// Core-side and scheduler-side channels of the frontend core arbiter.
// master = the arbiter itself, slave = the cores/scheduler environment.
interface frontend_core_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 128
);
  import frontend_command_definition_pkg::*;
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [NUM_CORES-1:0]              i_core_req_valid;
  frontend_command_t [NUM_CORES-1:0] i_core_req;
  logic [NUM_CORES-1:0]              o_core_req_ready;
  logic [NUM_CORES-1:0]              i_core_wdata_valid;
  logic [NUM_CORES-1:0]              i_core_wdata_last;
  logic [NUM_CORES-1:0][DATA_W-1:0]  i_core_wdata;
  logic [NUM_CORES-1:0]              o_core_wdata_ready;

  logic                              o_sched_cmd_valid;
  frontend_command_t                 o_sched_cmd;
  logic                              i_sched_cmd_ready;
  logic                              o_sched_wdata_valid;
  logic [DATA_W-1:0]                 o_sched_wdata;
  logic                              o_sched_wdata_last;
  logic                              i_sched_wdata_ready;

  logic                              i_rd_done_valid;
  logic [IW-1:0]                     i_rd_done_core;

  modport master (
    input  i_core_req_valid, i_core_req, i_core_wdata_valid, i_core_wdata_last, i_core_wdata,
    input  i_sched_cmd_ready, i_sched_wdata_ready, i_rd_done_valid, i_rd_done_core,
    output o_core_req_ready, o_core_wdata_ready, o_sched_cmd_valid, o_sched_cmd,
    output o_sched_wdata_valid, o_sched_wdata, o_sched_wdata_last
  );

  modport slave (
    output i_core_req_valid, i_core_req, i_core_wdata_valid, i_core_wdata_last, i_core_wdata,
    output i_sched_cmd_ready, i_sched_wdata_ready, i_rd_done_valid, i_rd_done_core,
    input  o_core_req_ready, o_core_wdata_ready, o_sched_cmd_valid, o_sched_cmd,
    input  o_sched_wdata_valid, o_sched_wdata, o_sched_wdata_last
  );
endinterface

// File: rtl/frontend_core_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_any && req[(int'(ptr) + k) % N]) begin
        gnt_any                             = 1'b1;
        gnt_idx                             = IW'((int'(ptr) + k) % N);
        gnt_onehot[(int'(ptr) + k) % N]     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/frontend_core_arbiter.sv
// Round-robin sharing of the scheduler command/write-data port between cores,
// with write-burst locking and per-core outstanding-read credits.
module frontend_core_arbiter
  import frontend_command_definition_pkg::*;
#(
  parameter  int NUM_CORES    = 4,
  parameter  int DATA_W       = 128,
  parameter  int MAX_RD_OUTST = 4,
  localparam int IW           = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int CW           = $clog2(MAX_RD_OUTST + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  frontend_core_arbiter_if.master bus,
  output logic [IW-1:0]           o_grant_core,
  output logic                    o_busy,
  output logic                    o_credit_err
);
  arb_state_t                     state, state_n;
  frontend_command_t              cmd_q;
  logic [IW-1:0]                  grant_q, rr_ptr, gnt_idx;
  logic [NUM_CORES-1:0][CW-1:0]   rd_cnt;
  logic [NUM_CORES-1:0]           eligible, gnt_onehot, rd_inc, rd_dec;
  logic                           gnt_any;
  logic [DATA_W-1:0]              wdata_mux;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    assign eligible[i] = bus.i_core_req_valid[i] &
                         ~((bus.i_core_req[i].op_type == OP_READ) &
                           (rd_cnt[i] == CW'(MAX_RD_OUTST)));
    assign rd_dec[i]   = bus.i_rd_done_valid & (bus.i_rd_done_core == IW'(i));
  end

  rr_arbiter #(.N(NUM_CORES)) u_rr (
    .req        (eligible),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  assign o_grant_core = grant_q;
  assign o_busy       = (state != ARB);
  assign wdata_mux    = bus.i_core_wdata[grant_q];

  // Outputs are gated by rst so nothing leaks out during a reset cycle.
  always_comb begin
    state_n                 = state;
    rd_inc                  = '0;
    bus.o_core_req_ready    = '0;
    bus.o_core_wdata_ready  = '0;
    bus.o_sched_cmd_valid   = 1'b0;
    bus.o_sched_cmd         = '0;
    bus.o_sched_wdata_valid = 1'b0;
    bus.o_sched_wdata       = '0;
    bus.o_sched_wdata_last  = 1'b0;
    if (!rst) begin
      case (state)
        ARB: if (gnt_any) begin
          bus.o_core_req_ready = gnt_onehot;
          rd_inc  = (bus.i_core_req[gnt_idx].op_type == OP_READ) ? gnt_onehot : '0;
          state_n = CMD;
        end
        CMD: begin
          bus.o_sched_cmd_valid = 1'b1;
          bus.o_sched_cmd       = cmd_q;
          if (bus.i_sched_cmd_ready)
            state_n = (cmd_q.op_type == OP_WRITE) ? WDATA : ARB;
        end
        WDATA: begin
          bus.o_sched_wdata_valid         = bus.i_core_wdata_valid[grant_q];
          bus.o_sched_wdata               = wdata_mux;
          bus.o_sched_wdata_last          = bus.i_core_wdata_last[grant_q];
          bus.o_core_wdata_ready[grant_q] = bus.i_sched_wdata_ready;
          if (bus.i_core_wdata_valid[grant_q] && bus.i_sched_wdata_ready &&
              bus.i_core_wdata_last[grant_q])
            state_n = ARB;
        end
        default: state_n = ARB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB;
      cmd_q        <= '0;
      grant_q      <= '0;
      rr_ptr       <= '0;
      rd_cnt       <= '0;
      o_credit_err <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ARB && gnt_any) begin
        cmd_q   <= bus.i_core_req[gnt_idx];
        grant_q <= gnt_idx;
        rr_ptr  <= (gnt_idx == IW'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;
      end
      // A grant and a returned credit on the same core cancel out.
      for (int i = 0; i < NUM_CORES; i++) begin
        if (rd_inc[i] && !rd_dec[i])
          rd_cnt[i] <= rd_cnt[i] + 1'b1;
        else if (rd_dec[i] && !rd_inc[i]) begin
          if (rd_cnt[i] == '0) o_credit_err <= 1'b1;
          else                 rd_cnt[i]    <= rd_cnt[i] - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_frontend_core_arbiter.sv
// Scoreboard bench for frontend_core_arbiter: per-core command/beat queues feed
// the DUT, expected commands/beats are queued at stimulus time and popped on handshakes.
module tb_frontend_core_arbiter;
  import frontend_command_definition_pkg::*;
  localparam int NC = 4, DW = 128, MAXR = 4;

  typedef struct packed { logic last; logic [DW-1:0] d; } beat_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] gnt;
  logic busy, cerr;
  always #5 clk = ~clk;

  frontend_core_arbiter_if #(.NUM_CORES(NC), .DATA_W(DW)) bus ();

  frontend_core_arbiter #(.NUM_CORES(NC), .DATA_W(DW), .MAX_RD_OUTST(MAXR)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .o_grant_core(gnt), .o_busy(busy), .o_credit_err(cerr)
  );

  int errs = 0, checks = 0, cyc = 0, last_hs = -1;
  bit chk_space = 1'b0, rand_wd = 1'b0;
  logic [NC-1:0] rdy_s = '0, wd_s = '0;
  frontend_command_t cq[NC][$];
  frontend_command_t exp_cmd[$];
  beat_t bq[NC][$];
  beat_t exp_beats[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input int c, input op_type_t op, input logic [7:0] id, input int nbeats,
                       input bit ex, output frontend_command_t x);
    beat_t b;
    x.op_type = op;
    x.addr    = $urandom;
    x.core_id = 3'(c);
    x.req_id  = id;
    cq[c].push_back(x);
    if (ex) exp_cmd.push_back(x);
    for (int k = 0; k < nbeats; k++) begin
      b.d    = {$urandom, $urandom, $urandom, $urandom};
      b.last = (k == nbeats - 1);
      bq[c].push_back(b);
      exp_beats.push_back(b);
    end
  endtask

  task automatic rd_done(input int c);
    @(posedge clk); #1;
    bus.i_rd_done_valid = 1'b1;
    bus.i_rd_done_core  = 2'(c);
    @(posedge clk); #1;
    bus.i_rd_done_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_cmd.size() != 0 || exp_beats.size() != 0 || busy) && n < 400) begin
      @(negedge clk); n++;
    end
    if (n >= 400) chk({tag, "_timeout"}, 1, 0);
    @(negedge clk);
  endtask

  // Core/scheduler-side driver: pops what was accepted, presents queue heads.
  initial begin
    bus.i_core_req_valid    = '0;
    bus.i_core_req          = '0;
    bus.i_core_wdata_valid  = '0;
    bus.i_core_wdata_last   = '0;
    bus.i_core_wdata        = '0;
    bus.i_sched_wdata_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < NC; i++) begin
        if (rdy_s[i] && cq[i].size() > 0) void'(cq[i].pop_front());
        if (wd_s[i] && bq[i].size() > 0) void'(bq[i].pop_front());
        bus.i_core_req_valid[i] = (cq[i].size() > 0);
        if (cq[i].size() > 0) bus.i_core_req[i] = cq[i][0];
        else                  bus.i_core_req[i] = '0;
        if (bq[i].size() > 0) begin
          bus.i_core_wdata_valid[i] = !rand_wd || ($urandom_range(0, 2) != 0);
          bus.i_core_wdata[i]       = bq[i][0].d;
          bus.i_core_wdata_last[i]  = bq[i][0].last;
        end else begin
          bus.i_core_wdata_valid[i] = 1'b0;
          bus.i_core_wdata[i]       = '0;
          bus.i_core_wdata_last[i]  = 1'b0;
        end
      end
      bus.i_sched_wdata_ready = rand_wd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares scheduler-side handshakes against the scoreboard.
  initial begin
    frontend_command_t e;
    beat_t b;
    forever begin
      @(negedge clk);
      rdy_s = bus.o_core_req_ready;
      wd_s  = bus.o_core_wdata_ready & bus.i_core_wdata_valid;
      if (!rst) begin
        if (|bus.o_core_req_ready)   chk("req_rdy_in_arb", busy, 0);
        if (|bus.o_core_wdata_ready) chk("wd_rdy_in_wdata", busy, 1);
        if (bus.o_sched_cmd_valid && bus.i_sched_cmd_ready) begin
          if (exp_cmd.size() == 0) chk("cmd_unexpected", 1, 0);
          else begin
            e = exp_cmd.pop_front();
            chk("cmd", bus.o_sched_cmd, e);
            chk("grant_core", gnt, e.core_id[1:0]);
            if (e.op_type == OP_READ) chk("write_lock", exp_beats.size(), 0);
            if (chk_space && last_hs >= 0) chk("cmd_spacing", cyc - last_hs, 2);
            last_hs = cyc;
          end
        end
        if (bus.o_sched_wdata_valid && bus.i_sched_wdata_ready) begin
          if (exp_beats.size() == 0) chk("beat_unexpected", 1, 0);
          else begin
            b = exp_beats.pop_front();
            chk("wdata", bus.o_sched_wdata, b.d);
            chk("wlast", bus.o_sched_wdata_last, b.last);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

  initial begin
    frontend_command_t x, y, snap;
    int n;
    bus.i_sched_cmd_ready = 1'b1;
    bus.i_rd_done_valid   = 1'b0;
    bus.i_rd_done_core    = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant", gnt, 0);
    chk("rst_cerr", cerr, 0);
    chk("rst_cmd_valid", bus.o_sched_cmd_valid, 0);
    chk("rst_wd_valid", bus.o_sched_wdata_valid, 0);
    chk("rst_req_ready", bus.o_core_req_ready, 0);
    @(posedge clk); #2 rst = 1'b0;

    // round-robin fairness: expected order 0,1,2,3,0 at 2-cycle spacing
    chk_space = 1'b1; last_hs = -1;
    issue(0, OP_READ, 8'h00, 0, 1, x);
    issue(1, OP_READ, 8'h01, 0, 1, x);
    issue(2, OP_READ, 8'h02, 0, 1, x);
    issue(3, OP_READ, 8'h03, 0, 1, x);
    issue(0, OP_READ, 8'h04, 0, 1, x);
    wait_idle("rr");
    chk_space = 1'b0;
    rd_done(0); rd_done(0); rd_done(1); rd_done(2); rd_done(3);

    // write lock: core 1 3-beat write (rr_ptr=1) ahead of core 2 read
    rand_wd = 1'b1;
    issue(1, OP_WRITE, 8'h10, 3, 1, x);
    issue(2, OP_READ,  8'h11, 0, 1, x);
    wait_idle("wlock");
    rand_wd = 1'b0;
    rd_done(2);

    // credit block: core 0 uses all 4 credits, 5th waits while core 3 proceeds
    for (int k = 0; k < 4; k++) issue(0, OP_READ, 8'(8'h20 + k), 0, 1, x);
    wait_idle("cred_fill");
    issue(0, OP_READ, 8'h24, 0, 0, x);
    issue(3, OP_READ, 8'h25, 0, 1, y);
    wait_idle("cred_other");
    repeat (4) @(negedge clk);
    chk("cred_blocked", cq[0].size(), 1);
    chk("cred_no_ready", bus.o_core_req_ready[0], 0);
    exp_cmd.push_back(x);
    rd_done(0);
    @(negedge clk);
    chk("cred_regrant", bus.o_core_req_ready, 4'b0001);
    wait_idle("cred_regrant");
    repeat (4) rd_done(0);
    rd_done(3);

    // simultaneous grant and credit return on core 2 at count 2
    issue(2, OP_READ, 8'h30, 0, 1, x);
    issue(2, OP_READ, 8'h31, 0, 1, x);
    wait_idle("sim_fill");
    issue(2, OP_READ, 8'h32, 0, 1, x);
    n = 0;
    @(negedge clk);
    while (!bus.o_core_req_ready[2] && n < 50) begin @(negedge clk); n++; end
    chk("sim_grant_seen", bus.o_core_req_ready[2], 1);
    bus.i_rd_done_valid = 1'b1;
    bus.i_rd_done_core  = 2'd2;
    @(posedge clk); #1 bus.i_rd_done_valid = 1'b0;
    wait_idle("sim_grant");
    // count must still be 2: exactly two more reads fit
    issue(2, OP_READ, 8'h33, 0, 1, x);
    issue(2, OP_READ, 8'h34, 0, 1, x);
    issue(2, OP_READ, 8'h35, 0, 0, x);
    wait_idle("sim_probe");
    repeat (4) @(negedge clk);
    chk("sim_cnt_held", cq[2].size(), 1);
    exp_cmd.push_back(x);
    rd_done(2);
    wait_idle("sim_release");
    repeat (4) rd_done(2);

    // back-pressure: rr_ptr=3, so core 3 wins over core 1 and must hold
    @(posedge clk); #2 bus.i_sched_cmd_ready = 1'b0;
    issue(1, OP_READ, 8'h40, 0, 0, x);
    issue(3, OP_READ, 8'h41, 0, 0, y);
    exp_cmd.push_back(y);
    exp_cmd.push_back(x);
    n = 0;
    @(negedge clk);
    while (!bus.o_sched_cmd_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_first_cmd", bus.o_sched_cmd, y);
    snap = bus.o_sched_cmd;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", bus.o_sched_cmd_valid, 1);
      chk("bp_stable", bus.o_sched_cmd, snap);
      chk("bp_no_ready", bus.o_core_req_ready, 0);
    end
    @(posedge clk); #2 bus.i_sched_cmd_ready = 1'b1;
    wait_idle("bp");
    chk("cerr_clean", cerr, 0);

    // reset mid-write: core 3 burst, reset lands on beat 2 (core 1 still holds a credit)
    issue(3, OP_WRITE, 8'h50, 3, 1, x);
    n = 0;
    @(negedge clk);
    while (exp_beats.size() != 2 && n < 50) begin @(negedge clk); n++; end
    chk("rw_beat1", exp_beats.size(), 2);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rw_busy", busy, 0);
    chk("rw_grant", gnt, 0);
    chk("rw_cmd_valid", bus.o_sched_cmd_valid, 0);
    chk("rw_cmd", bus.o_sched_cmd, 0);
    chk("rw_wd_valid", bus.o_sched_wdata_valid, 0);
    chk("rw_wdata", bus.o_sched_wdata, 0);
    chk("rw_wlast", bus.o_sched_wdata_last, 0);
    chk("rw_wd_ready", bus.o_core_wdata_ready, 0);
    chk("rw_req_ready", bus.o_core_req_ready, 0);
    for (int i = 0; i < NC; i++) begin cq[i].delete(); bq[i].delete(); end
    exp_cmd.delete();
    exp_beats.delete();
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("post_busy", busy, 0);
    chk("post_cerr", cerr, 0);
    rd_done(1);
    @(negedge clk);
    chk("cerr_set", cerr, 1);
    @(negedge clk);
    chk("cerr_sticky", cerr, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
